pll_reset_seq: RTL

Reset sequencer that sits directly downstream of the PLL. It runs in the PLL output clock domain, synchronizes and debounces the PLL lock indication, and holds the design reset until lock is stable. It then releases two staged resets: core first, peripherals later. On loss of lock, or on a soft-reset request, it re-asserts the resets and repeats the sequence.

---
 rtl/pll_reset_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Reset sequencer placed directly after the PLL, clocked by the PLL output
// clock. It synchronizes the asynchronous lock indication, debounces it and
// holds the core reset until lock has been stable. It then releases the core
// reset, and after a further gap the peripheral reset. Loss of lock sends the
// sequence back to the start. A soft-reset request from RUN re-runs the hold
// phase.
//
// Optional feature macro: PLL_RESET_SEQ_LOSS_COUNT_EN
//   defined   -> loss_count port and its 8-bit saturating lock-loss counter
//   undefined -> port and counter absent; all other behaviour unchanged
//
// Parameters:
//   LOCK_CYCLES  consecutive synchronized-lock-high cycles before hold (>=1)
//   HOLD_CYCLES  cycles out_reset stays high after debounce completes (>=1)
//   STAGE_GAP    cycles between out_reset and out_reset_late release (>=0)
//
// Ports:
//   clock          in   PLL output clock, the only clock of the block
//   reset          in   synchronous active-high block reset
//   pll_lock       in   asynchronous PLL lock indication
//   soft_rst_req   in   single-cycle request to re-run the hold phase
//   out_reset      out  core reset, active-high
//   out_reset_late out  peripheral reset, active-high
//   ready          out  high when both resets are released
//   loss_count     out  [7:0] saturating lock-loss count (macro only)
// -----------------------------------------------------------------------------
module pll_reset_seq #(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       out_reset,
  output logic       out_reset_late,
  output logic       ready
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0] loss_count
`endif
);

  localparam int CNT_MAX = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_W   = (STAGE_GAP > 0) ? $clog2(STAGE_GAP + 1) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(STAGE_GAP);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    DEBOUNCE  = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Two-flop synchronizer; only lock_s_q is used for decisions.
  logic s1_q, s1_d;
  logic lock_s_q, lock_s_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic out_reset_q, out_reset_d;
  logic out_reset_late_q, out_reset_late_d;
  logic ready_q, ready_d;

  always_comb begin
    s1_d     = pll_lock;
    lock_s_d = s1_q;
  end

  // Next-state logic. Lock loss is checked first in every state so that it
  // always wins over a simultaneous soft-reset request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = DEBOUNCE;
          cnt_d   = '0;
        end
      end

      DEBOUNCE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (soft_rst_req) begin
          // A new request stretches the hold window from the start.
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          gap_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (soft_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so they change
  // on the same edge as the state register and never glitch.
  always_comb begin
    out_reset_d      = (state_d != RUN);
    out_reset_late_d = !((state_d == RUN) && (gap_d == GAP_LAST));
    ready_d          = !out_reset_late_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q             <= 1'b0;
      lock_s_q         <= 1'b0;
      state_q          <= WAIT_LOCK;
      cnt_q            <= '0;
      gap_q            <= '0;
      out_reset_q      <= 1'b1;
      out_reset_late_q <= 1'b1;
      ready_q          <= 1'b0;
    end else begin
      s1_q             <= s1_d;
      lock_s_q         <= lock_s_d;
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      gap_q            <= gap_d;
      out_reset_q      <= out_reset_d;
      out_reset_late_q <= out_reset_late_d;
      ready_q          <= ready_d;
    end
  end

  assign out_reset      = out_reset_q;
  assign out_reset_late = out_reset_late_q;
  assign ready          = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  // A loss is counted only when lock drops while the sequence is in RUN.
  logic [7:0] loss_count_q, loss_count_d;
  logic       loss_inc;

  always_comb begin
    loss_inc     = (state_q == RUN) && !lock_s_q;
    loss_count_d = loss_count_q;
    if (loss_inc && (loss_count_q != 8'hFF)) begin
      loss_count_d = loss_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      loss_count_q <= 8'd0;
    end else begin
      loss_count_q <= loss_count_d;
    end
  end

  assign loss_count = loss_count_q;
`endif

endmodule
